// File: rtl/mig_tt_sweep_ctrl.sv
// mig_tt_sweep_ctrl: walks every input pattern of an N_IN-input function
// under test, captures its response and presents the 2^N_IN-bit truth table
// to the host through a valid/ready handshake.
//
// Optional feature (define MIG_TT_SWEEP_ONSET_CNT_EN): onset_cnt counts the
// captured 1s of the sweep and is_balanced flags a table with exactly half
// of its entries set.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; x_out and tt hold their last values
// S_SWEEP | one new pattern issued on x_out every cycle, captures running
// S_DRAIN | all patterns issued, waiting for the latency pipeline to empty
// S_DONE  | truth table complete, tt_valid high until the host takes it
module mig_tt_sweep_ctrl #(
    parameter int N_IN       = 7,
    parameter int SAMPLE_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    output logic                   busy,
    output logic [N_IN-1:0]        x_out,
    input  logic                   f_in,
    output logic                   tt_valid,
    input  logic                   tt_ready,
    output logic [(1<<N_IN)-1:0]   tt
`ifdef MIG_TT_SWEEP_ONSET_CNT_EN
    ,
    output logic [N_IN:0]          onset_cnt,
    output logic                   is_balanced
`endif
);

    localparam int TT_W = 1 << N_IN;

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

    state_t                state;
    logic [N_IN:0]         issue_cnt;
    logic [N_IN-1:0]       cap_cnt;
    logic [SAMPLE_LAT-1:0] vld_pipe;
    logic [SAMPLE_LAT:0]   pipe_shift;
    logic                  issue_en;
    logic                  issue_now;
    logic                  cap_en;
    logic                  cap_last;

    // The carry bit of issue_cnt marks that every pattern has been issued.
    assign issue_en   = (state == S_SWEEP) && !issue_cnt[N_IN];
    assign issue_now  = ((state == S_IDLE) && start) || issue_en;
    assign pipe_shift = {vld_pipe, issue_now};
    assign cap_en     = vld_pipe[SAMPLE_LAT-1];
    assign cap_last   = cap_en && (cap_cnt == {N_IN{1'b1}});

`ifdef MIG_TT_SWEEP_ONSET_CNT_EN
    // Balanced means exactly half of the truth table entries are 1.
    assign is_balanced = tt_valid && (onset_cnt == (N_IN+1)'(TT_W / 2));
`endif

    // Sweep sequencer: pattern issue, latency-aligned capture and handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            x_out     <= '0;
            tt        <= '0;
            tt_valid  <= 1'b0;
            issue_cnt <= '0;
            cap_cnt   <= '0;
            vld_pipe  <= '0;
`ifdef MIG_TT_SWEEP_ONSET_CNT_EN
            onset_cnt <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    // start wins over a simultaneous abort; pattern 0 goes
                    // out on the accepting edge itself.
                    if (start) begin
                        state     <= S_SWEEP;
                        busy      <= 1'b1;
                        tt        <= '0;
                        x_out     <= '0;
                        issue_cnt <= {{N_IN{1'b0}}, 1'b1};
                        cap_cnt   <= '0;
                        vld_pipe  <= pipe_shift[SAMPLE_LAT-1:0];
`ifdef MIG_TT_SWEEP_ONSET_CNT_EN
                        onset_cnt <= '0;
`endif
                    end
                end
                S_SWEEP, S_DRAIN: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        x_out     <= '0;
                        issue_cnt <= '0;
                        cap_cnt   <= '0;
                        vld_pipe  <= '0;
                    end else begin
                        vld_pipe <= pipe_shift[SAMPLE_LAT-1:0];
                        if (issue_en) begin
                            x_out     <= issue_cnt[N_IN-1:0];
                            issue_cnt <= issue_cnt + {{N_IN{1'b0}}, 1'b1};
                        end
                        if (cap_en) begin
                            tt[cap_cnt] <= f_in;
                            cap_cnt     <= cap_cnt + {{(N_IN-1){1'b0}}, 1'b1};
`ifdef MIG_TT_SWEEP_ONSET_CNT_EN
                            onset_cnt   <= onset_cnt + {{N_IN{1'b0}}, f_in};
`endif
                        end
                        // With a one-cycle latency the last capture coincides
                        // with the carry, so DRAIN is skipped entirely.
                        if (cap_last) begin
                            state    <= S_DONE;
                            busy     <= 1'b0;
                            tt_valid <= 1'b1;
                        end else if (issue_cnt[N_IN]) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DONE: begin
                    // start is deliberately not looked at here.
                    if (tt_valid && tt_ready) begin
                        state     <= S_IDLE;
                        tt_valid  <= 1'b0;
                        issue_cnt <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mig_tt_sweep_ctrl.md
Name: mig_tt_sweep_ctrl

Overview:
- Sequencer that drives every input pattern into a combinational 7-input majority-gate function-under-test (FUT) and captures its response.
- Assembles the full 2^N-bit truth table used by the classification flow.
- Sits between the classification host (start/result handshake) and one FUT instance, which it owns exclusively while busy.
- Supports a configurable sampling latency so registered or pipelined FUT wrappers can be swept as well.

Parameters:
- N_IN, 7, number of FUT inputs; the truth table is 2^N_IN bits wide.
- SAMPLE_LAT, 1, cycles from a pattern being driven on x_out to f_in being valid for that pattern (>=1; 1 means a purely combinational FUT).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  sweep request; accepted only in IDLE.
- abort  in  1  cancels a sweep in progress.
- busy  out  1  high in SWEEP and DRAIN.
- x_out  out  N_IN  pattern driven to the FUT inputs x0..x(N_IN-1); bit i drives xi.
- f_in  in  1  FUT output (out).
- tt_valid  out  1  truth table is complete and held.
- tt_ready  in  1  host accepts the result.
- tt  out  2^N_IN  truth table; tt[k] = FUT response to pattern k.

Behaviour:
- Reset (asynchronous, immediate, including mid-sweep): state=IDLE; busy=0; x_out=0; tt=0; tt_valid=0; issue counter, capture counter and LAT-deep valid pipeline all cleared.
- States:
  - IDLE: start=1 -> SWEEP; tt cleared to 0 on the same edge; issue index set to 0.
  - SWEEP: x_out = issue index, which increments by 1 per cycle from 0 to 2^N_IN-1 with no gaps. After the edge that issues the last pattern -> DRAIN.
  - DRAIN: x_out holds the last pattern (all ones) until the pipeline empties.
  - DONE: tt_valid=1; tt and x_out are stable; busy=0.
- Capture: the pattern issued after edge E0+k (E0 = start-accepting edge) is captured into tt[k] at edge E0+k+SAMPLE_LAT.
  - Capture uses a shift pipeline of valid bits plus a capture counter, not a recomputed index.
- Completion: tt_valid rises on the edge that captures tt[2^N_IN-1], exactly 2^N_IN+SAMPLE_LAT-1 edges after E0 (128 for the defaults).
  - With SAMPLE_LAT=1, DRAIN lasts 0 cycles: SWEEP -> DONE directly.
- Result handshake: in DONE, tt_valid & tt_ready on an edge -> IDLE; tt_valid drops; tt keeps its value until the next start.
- start is ignored outside IDLE, including start asserted together with tt_ready in DONE: it must be re-asserted in IDLE.
- abort:
  - Honoured in SWEEP or DRAIN -> IDLE on the next edge; x_out=0; pipeline flushed; tt_valid stays 0; tt contents undefined but stable.
  - Ignored in IDLE and DONE.
  - abort and start together in IDLE: start wins.
- Counter wrap: the issue counter is N_IN+1 bits wide so end-of-sweep is detected by the carry; no pattern is issued twice.
- x_out is a register output with no combinational path from any input.

Optional Feature:
- Macro: MIG_TT_SWEEP_ONSET_CNT_EN.
- When defined:
  - Adds output onset_cnt (N_IN+1 bits) counting captured 1s during the sweep.
  - onset_cnt is cleared on start acceptance and reset, and is valid and held while tt_valid=1.
  - Adds output is_balanced = (onset_cnt == 2^(N_IN-1)) while tt_valid=1, else 0.
- When undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Defaults, FUT f=x0&x1, start pulse -> x_out walks 0..127 on consecutive cycles; tt_valid after 128 edges; tt = 128'h8888...8888; onset_cnt=32; is_balanced=0.
- FUT f=x6, SAMPLE_LAT=3 with f_in delayed 2 extra registers -> tt = {64 ones, 64 zeros}; tt_valid after 130 edges; onset_cnt=64; is_balanced=1.
- FUT constant 1 with tt_ready held low for 20 cycles -> tt all ones and stable; onset_cnt=128; busy=0; start pulses during the hold are ignored; tt_ready=1 -> IDLE next edge.
- abort at issue index 50 -> IDLE next edge, x_out=0, tt_valid never rises; an immediate new start with FUT constant 0 -> tt=0, onset_cnt=0.
- rst asserted at issue index 77 (asynchronous, mid-cycle) -> busy, tt_valid, x_out and tt clear immediately; after release, a full sweep of the majority-chain FUT matches the software model's 128-bit table.
- start asserted every cycle continuously -> sweeps run back-to-back, each separated by the DONE+handshake and an IDLE cycle; no pattern is skipped or duplicated.
